// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine among NUM_REQ requesters,
// with one-hot slave select, inter-frame guard time and a hung-transfer timeout.
module spi_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] tx_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic [7:0]           rx_data,
  output logic                 spi_start,
  output logic [7:0]           spi_tx,
  output logic [NUM_REQ-1:0]   spi_cs_sel,
  input  logic                 spi_busy,
  input  logic                 spi_done,
  input  logic [7:0]           spi_rx
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int IDX_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [IDX_W-1:0] NREQ_IDX = IDX_W'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_next;
  logic [PTR_W-1:0]   winner, winner_next;
  logic [PTR_W-1:0]   pick;
  logic               pick_valid;
  logic [IDX_W-1:0]   idx;
  logic [TO_W-1:0]    to_cnt, to_cnt_next;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_next;
  logic [NUM_REQ-1:0] gnt_next, done_next, err_next;
  logic [7:0]         rx_data_next, spi_tx_next;

  // First requester found scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + IDX_W'(i);
      if (idx >= NREQ_IDX) idx = idx - NREQ_IDX;
      if (!pick_valid && req[idx[PTR_W-1:0]]) begin
        pick       = idx[PTR_W-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      winner  <= '0;
      to_cnt  <= '0;
      gap_cnt <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      rx_data <= '0;
      spi_tx  <= '0;
    end else begin
      state   <= state_next;
      rr_ptr  <= rr_ptr_next;
      winner  <= winner_next;
      to_cnt  <= to_cnt_next;
      gap_cnt <= gap_cnt_next;
      gnt     <= gnt_next;
      done    <= done_next;
      err     <= err_next;
      rx_data <= rx_data_next;
      spi_tx  <= spi_tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    rr_ptr_next  = rr_ptr;
    winner_next  = winner;
    to_cnt_next  = to_cnt;
    gap_cnt_next = gap_cnt;
    gnt_next     = gnt;
    done_next    = '0;
    err_next     = '0;
    rx_data_next = rx_data;
    spi_tx_next  = spi_tx;

    case (state)
      IDLE: begin
        if (pick_valid && !spi_busy) begin
          state_next  = LAUNCH;
          winner_next = pick;
          gnt_next    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          spi_tx_next = tx_data[8*pick +: 8];
          to_cnt_next = '0;
        end
      end

      // The launch cycle is counted, so err lands exactly TIMEOUT_CYC cycles after spi_start.
      LAUNCH: begin
        state_next  = WAIT;
        to_cnt_next = to_cnt + TO_W'(1);
      end

      WAIT: begin
        if (spi_done || to_cnt == TO_LAST) begin
          if (spi_done) begin
            rx_data_next = spi_rx;
            done_next    = gnt;
          end else begin
            err_next     = gnt;
          end
          state_next   = GAP;
          gnt_next     = '0;
          gap_cnt_next = '0;
          rr_ptr_next  = (winner == LAST_IDX) ? '0 : winner + PTR_W'(1);
        end else if (to_cnt != {TO_W{1'b1}}) begin
          to_cnt_next = to_cnt + TO_W'(1);
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) state_next = IDLE;
        else                     gap_cnt_next = gap_cnt + GAP_W'(1);
      end

      default: state_next = IDLE;
    endcase
  end

  assign spi_cs_sel = gnt;
  assign spi_start  = (state == LAUNCH);

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Randomized bench for spi_req_arbiter: a frame-level model predicts the round-robin
// winner and the cycle-exact timing of launch, completion, timeout and guard gap.
module tb_spi_req_arbiter;

  localparam int N   = 4;
  localparam int GAP = 8;
  localparam int TO  = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] tx_data;
  logic [N-1:0]   gnt, done, err, spi_cs_sel;
  logic [7:0]     rx_data, spi_tx, spi_rx;
  logic           spi_start, spi_busy, spi_done;

  int         vectors     = 0;
  int         miscompares = 0;
  int         m_rr        = 0;
  logic [7:0] m_rx        = 8'h00;

  always #5 clk = ~clk;

  spi_req_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .tx_data(tx_data),
    .gnt(gnt), .done(done), .err(err), .rx_data(rx_data),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_cs_sel(spi_cs_sel),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx(spi_rx)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [N-1:0] g, input logic [N-1:0] c,
                                       input logic [N-1:0] d, input logic [N-1:0] e,
                                       input logic s, input logic [7:0] rx);
    return 64'({g, c, d, e, s, rx});
  endfunction

  function automatic logic [63:0] observed();
    return pack(gnt, spi_cs_sel, done, err, spi_start, rx_data);
  endfunction

  // Round-robin rule: first set request scanning from the pointer, wrapping modulo N.
  function automatic int model_pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(m_rr + i) % N]) return (m_rr + i) % N;
    return 0;
  endfunction

  function automatic logic [8*N-1:0] rand_tx();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'($urandom);
    return v;
  endfunction

  // Called at a negedge while the DUT is idle; returns at a negedge in the next idle cycle.
  // lat >= TO means the engine never answers.
  task automatic run_frame(input logic [N-1:0] r, input logic [8*N-1:0] txv, input int lat,
                           input logic [7:0] rxv, input int n_idle, input int n_busy,
                           input bit drop, input bit spur, input int exp_w);
    int         w;
    int         pulse_k;
    bit         ok;
    logic [N-1:0] oh;
    w       = (exp_w >= 0) ? exp_w : model_pick(r);
    oh      = N'(1) << w;
    ok      = (lat <= TO - 1);
    pulse_k = ok ? lat + 1 : TO;

    for (int i = 0; i < n_idle; i++) begin
      req      = '0;
      spi_busy = 1'($urandom_range(0, 1));
      spi_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      spi_rx   = 8'($urandom);
      @(negedge clk);
      checkOutput("idle", observed(), pack('0, '0, '0, '0, 1'b0, m_rx));
    end
    for (int i = 0; i < n_busy; i++) begin
      req      = r;
      spi_busy = 1'b1;
      spi_done = 1'b0;
      @(negedge clk);
      checkOutput("busy_hold", observed(), pack('0, '0, '0, '0, 1'b0, m_rx));
    end

    req      = r;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    tx_data  = txv;
    @(negedge clk);
    checkOutput("launch", observed(), pack(oh, oh, '0, '0, 1'b1, m_rx));
    checkOutput("spi_tx", 64'(spi_tx), 64'(txv[8*w +: 8]));

    tx_data  = rand_tx();
    spi_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
    spi_rx   = 8'($urandom);
    for (int k = 1; k < pulse_k; k++) begin
      @(negedge clk);
      checkOutput("wait", observed(), pack(oh, oh, '0, '0, 1'b0, m_rx));
      if (k > 1) checkOutput("tx_hold", 64'(spi_tx), 64'(txv[8*w +: 8]));
      spi_done = ok && (k == lat);
      spi_rx   = spi_done ? rxv : 8'($urandom);
      if (drop && k == 2) req = req & ~oh;
    end

    @(negedge clk);
    checkOutput(ok ? "done_pulse" : "err_pulse", observed(),
                pack('0, '0, ok ? oh : '0, ok ? '0 : oh, 1'b0, ok ? rxv : m_rx));
    if (ok) m_rx = rxv;
    m_rr = (w + 1) % N;

    for (int g = 0; g < GAP; g++) begin
      spi_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      spi_rx   = 8'($urandom);
      @(negedge clk);
      checkOutput("gap", observed(), pack('0, '0, '0, '0, 1'b0, m_rx));
    end
    spi_done = 1'b0;
  endtask

  // Aborts a frame 10 cycles into WAIT with an asynchronous reset.
  task automatic abort_with_reset(input logic [N-1:0] r);
    req      = r;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    tx_data  = rand_tx();
    @(negedge clk);
    checkOutput("abort_launch", 64'(spi_start), 64'(1));
    for (int k = 0; k < 10; k++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset", observed(), pack('0, '0, '0, '0, 1'b0, 8'h00));
    checkOutput("async_reset_tx", 64'(spi_tx), 64'(0));
    m_rr = 0;
    m_rx = 8'h00;
    req  = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("in_reset", observed(), pack('0, '0, '0, '0, 1'b0, m_rx));
    end
    rst = 1'b1;
  endtask

  initial begin
    int             order [6] = '{0, 1, 3, 0, 1, 3};
    logic [8*N-1:0] txv;
    int             sel;
    int             lat;

    rst      = 1'b0;
    req      = '0;
    tx_data  = '0;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_rx   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", observed(), pack('0, '0, '0, '0, 1'b0, 8'h00));
    checkOutput("reset_tx", 64'(spi_tx), 64'(0));
    rst = 1'b1;

    // Held 1011: round-robin order 0,1,3 repeating, back-to-back frames.
    for (int i = 0; i < 6; i++)
      run_frame(4'b1011, rand_tx(), 10 + i, 8'($urandom), 0, 0, 1'b0, 1'b0, order[i]);

    // Requester 0 drops mid-frame; its done still arrives, then 1 wins.
    run_frame(4'b0011, rand_tx(), 20, 8'($urandom), 0, 0, 1'b1, 1'b0, 0);
    run_frame(4'b0010, rand_tx(), 15, 8'($urandom), 0, 0, 1'b0, 1'b0, 1);

    txv = rand_tx();
    txv[23:16] = 8'hA3;
    run_frame(4'b0100, txv, 64, 8'h5C, 0, 0, 1'b0, 1'b0, 2);

    run_frame(4'b0010, rand_tx(), TO, 8'h00, 0, 0, 1'b0, 1'b0, 1);

    // Completion on the last timeout cycle; spurious spi_done while idle.
    run_frame(4'b0001, rand_tx(), TO - 1, 8'h3C, 3, 0, 1'b0, 1'b1, 0);

    run_frame(4'b0010, rand_tx(), 12, 8'($urandom), 0, 1, 1'b0, 1'b0, 1);
    abort_with_reset(4'b0100);
    run_frame(4'b1111, rand_tx(), 9, 8'($urandom), 1, 0, 1'b0, 1'b0, 0);
    run_frame(4'b1000, rand_tx(), 9, 8'($urandom), 0, 0, 1'b0, 1'b0, 3);

    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0)      lat = TO;
      else if (sel == 1) lat = TO - 1;
      else               lat = $urandom_range(1, 40);
      run_frame(4'($urandom_range(1, 2**N - 1)), rand_tx(), lat, 8'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
